// File: rtl/crc16_serial_checker.sv
// Serial CRC-16 receiver/checker: MSB-first data word followed by its CRC,
// recomputed on the fly and flagged pass/fail at end of frame.
module crc16_serial_checker #(
  parameter int          DATA_W = 32,
  parameter logic [15:0] POLY   = 16'h1021,
  parameter logic [15:0] INIT   = 16'h0000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              bit_in_i,
  input  logic              bit_valid_i,
  input  logic              sof_i,
  output logic              busy_o,
  output logic [DATA_W-1:0] data_out_o,
  output logic [15:0]       crc_rx_o,
  output logic [15:0]       crc_calc_o,
  output logic              done_o,
  output logic              crc_ok_o,
  output logic              crc_err_o
);

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_CRC} state_e;

  localparam logic [5:0] LAST_DATA = 6'(DATA_W - 1);
  localparam logic [5:0] LAST_CRC  = 6'd15;

  state_e              state_q;
  logic [5:0]          cnt_q;
  logic [DATA_W-1:0]   dsr_q;
  logic [DATA_W-1:0]   data_q;
  logic [15:0]         rx_q;
  logic [15:0]         crc_q;
  logic                done_q;
  logic                ok_q;
  logic                err_q;

  logic [15:0]         crc_step_d;
  logic [15:0]         crc_init_d;

  // crc_init_d restarts from INIT so a sof bit never inherits the old remainder
  always_comb begin
    crc_step_d = {crc_q[14:0], 1'b0} ^ ((bit_in_i ^ crc_q[15]) ? POLY : 16'h0000);
    crc_init_d = {INIT[14:0], 1'b0} ^ ((bit_in_i ^ INIT[15]) ? POLY : 16'h0000);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= 6'd0;
      dsr_q   <= '0;
      data_q  <= '0;
      rx_q    <= 16'h0000;
      crc_q   <= INIT;
      done_q  <= 1'b0;
      ok_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (bit_valid_i) begin
        if (sof_i) begin
          state_q <= S_DATA;
          cnt_q   <= 6'd1;
          crc_q   <= crc_init_d;
          dsr_q   <= {dsr_q[DATA_W-2:0], bit_in_i};
          ok_q    <= 1'b0;
          err_q   <= 1'b0;
        end else begin
          case (state_q)
            S_DATA: begin
              dsr_q <= {dsr_q[DATA_W-2:0], bit_in_i};
              crc_q <= crc_step_d;
              if (cnt_q == LAST_DATA) begin
                state_q <= S_CRC;
                cnt_q   <= 6'd0;
              end else begin
                cnt_q <= cnt_q + 6'd1;
              end
            end
            S_CRC: begin
              rx_q  <= {rx_q[14:0], bit_in_i};
              crc_q <= crc_step_d;
              if (cnt_q == LAST_CRC) begin
                state_q <= S_IDLE;
                cnt_q   <= 6'd0;
                data_q  <= dsr_q;
                done_q  <= 1'b1;
                ok_q    <= (crc_step_d == 16'h0000);
                err_q   <= (crc_step_d != 16'h0000);
              end else begin
                cnt_q <= cnt_q + 6'd1;
              end
            end
            default: ;
          endcase
        end
      end
    end
  end

  assign busy_o     = (state_q != S_IDLE);
  assign data_out_o = data_q;
  assign crc_rx_o   = rx_q;
  assign crc_calc_o = crc_q;
  assign done_o     = done_q;
  assign crc_ok_o   = ok_q;
  assign crc_err_o  = err_q;

endmodule

// File: tb/tb_crc16_serial_checker.sv
// Directed + randomized bench for crc16_serial_checker; reference CRC is
// computed as a polynomial remainder by long division.
module tb_crc16_serial_checker;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        bit_in = 1'b0;
  logic        bit_valid = 1'b0;
  logic        sof = 1'b0;
  logic        busy;
  logic [31:0] data_out;
  logic [15:0] crc_rx;
  logic [15:0] crc_calc;
  logic        done;
  logic        crc_ok;
  logic        crc_err;

  crc16_serial_checker #(.DATA_W(32), .POLY(16'h1021), .INIT(16'h0000)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bit_in_i   (bit_in),
    .bit_valid_i(bit_valid),
    .sof_i      (sof),
    .busy_o     (busy),
    .data_out_o (data_out),
    .crc_rx_o   (crc_rx),
    .crc_calc_o (crc_calc),
    .done_o     (done),
    .crc_ok_o   (crc_ok),
    .crc_err_o  (crc_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;
  int done_cyc[$];
  logic done_ok[$];

  always @(negedge clk) begin
    if (done) begin
      done_cyc.push_back(cyc);
      done_ok.push_back(crc_ok);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  // Remainder of v(x) divided by x^16+x^12+x^5+1
  function automatic logic [15:0] poly_mod(input logic [63:0] v);
    logic [63:0] g;
    logic [63:0] r;
    g = 64'h11021;
    r = v;
    for (int i = 63; i >= 16; i--)
      if (r[i]) r = r ^ (g << (i - 16));
    return r[15:0];
  endfunction

  function automatic logic [15:0] crc_of(input logic [31:0] d);
    return poly_mod({16'h0000, d, 16'h0000});
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drives the first n bits of frame {d,c}; 3 idle cycles after bits s1/s2/s3
  task automatic send_frame(input logic [31:0] d, input logic [15:0] c, input int n,
                            input int s1, input int s2, input int s3, output int start);
    logic [47:0] f;
    f = {d, c};
    start = 0;
    for (int i = 1; i <= n; i++) begin
      @(negedge clk);
      if (i == 1) start = cyc;
      if (i == 3) chk("busy_mid", 64'(busy), 64'd1);
      bit_in = f[48-i];
      bit_valid = 1'b1;
      sof = (i == 1);
      if (i == s1 || i == s2 || i == s3) begin
        repeat (3) begin
          @(negedge clk);
          bit_valid = 1'b0;
          sof = 1'($urandom);
          bit_in = 1'($urandom);
        end
      end
    end
  endtask

  task automatic finish_check(input string tag, input logic [31:0] d, input logic [15:0] c,
                              input int start, input int nstall);
    logic [15:0] rem;
    rem = poly_mod({d, c, 16'h0000});
    @(negedge clk);
    bit_valid = 1'b0;
    sof = 1'b0;
    chk({tag, "_done"}, 64'(done), 64'd1);
    chk({tag, "_busy_low"}, 64'(busy), 64'd0);
    chk({tag, "_latency"}, 64'(cyc - start), 64'(48 + 3 * nstall));
    chk({tag, "_data"}, 64'(data_out), 64'(d));
    chk({tag, "_crc_rx"}, 64'(crc_rx), 64'(c));
    chk({tag, "_crc_calc"}, 64'(crc_calc), 64'(rem));
    chk({tag, "_ok"}, 64'(crc_ok), 64'(rem == 16'h0000));
    chk({tag, "_err"}, 64'(crc_err), 64'(rem != 16'h0000));
    @(negedge clk);
    chk({tag, "_done_1cyc"}, 64'(done), 64'd0);
    chk({tag, "_ok_held"}, 64'(crc_ok), 64'(rem == 16'h0000));
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_data"}, 64'(data_out), 64'd0);
    chk({tag, "_crc_rx"}, 64'(crc_rx), 64'd0);
    chk({tag, "_crc_calc"}, 64'(crc_calc), 64'd0);
    chk({tag, "_done"}, 64'(done), 64'd0);
    chk({tag, "_ok"}, 64'(crc_ok), 64'd0);
    chk({tag, "_err"}, 64'(crc_err), 64'd0);
  endtask

  initial begin
    int st;
    int st2;
    int n0;
    logic [31:0] d;
    logic [15:0] c;

    repeat (2) @(negedge clk);
    check_reset_vals("rst");
    rst_n = 1'b1;
    @(negedge clk);

    chk("ref_crc_1", 64'(crc_of(32'h1)), 64'h1021);

    // Good frame
    send_frame(32'h1, 16'h1021, 48, 0, 0, 0, st);
    finish_check("good", 32'h1, 16'h1021, st, 0);

    // Bad frame
    send_frame(32'h2, 16'h2043, 48, 0, 0, 0, st);
    finish_check("bad", 32'h2, 16'h2043, st, 0);

    // Stalls after bits 5, 32, 40
    send_frame(32'h2, 16'h2042, 48, 5, 32, 40, st);
    finish_check("stall", 32'h2, 16'h2042, st, 3);

    // Abort at bit 20 and restart
    n0 = done_cyc.size();
    send_frame($urandom, 16'($urandom), 19, 0, 0, 0, st);
    send_frame(32'h1, 16'h1021, 48, 0, 0, 0, st);
    finish_check("abort", 32'h1, 16'h1021, st, 0);
    chk("abort_one_done", 64'(done_cyc.size() - n0), 64'd1);

    // Reset asserted during bit 40
    n0 = done_cyc.size();
    send_frame(32'h1, 16'h1021, 39, 0, 0, 0, st);
    @(negedge clk);
    bit_in = 1'b1;
    bit_valid = 1'b1;
    rst_n = 1'b0;
    #1;
    check_reset_vals("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    bit_valid = 1'b0;
    repeat (12) @(negedge clk);
    chk("midrst_no_done", 64'(done_cyc.size() - n0), 64'd0);
    d = $urandom;
    send_frame(d, crc_of(d), 48, 0, 0, 0, st);
    finish_check("postrst", d, crc_of(d), st, 0);

    // Back-to-back
    n0 = done_cyc.size();
    d = $urandom;
    send_frame(32'h1, 16'h1021, 48, 0, 0, 0, st);
    send_frame(d, crc_of(d), 48, 0, 0, 0, st2);
    finish_check("b2b", d, crc_of(d), st2, 0);
    chk("b2b_count", 64'(done_cyc.size() - n0), 64'd2);
    if (done_cyc.size() - n0 == 2) begin
      chk("b2b_spacing", 64'(done_cyc[n0+1] - done_cyc[n0]), 64'd48);
      chk("b2b_ok1", 64'(done_ok[n0]), 64'd1);
      chk("b2b_ok2", 64'(done_ok[n0+1]), 64'd1);
    end

    // Randomized frames, good and corrupted, with random stalls
    for (int k = 0; k < 8; k++) begin
      d = $urandom;
      c = crc_of(d);
      if ($urandom_range(0, 1) == 1) c = c ^ (16'h1 << $urandom_range(0, 15));
      send_frame(d, c, 48, $urandom_range(1, 15), $urandom_range(16, 31),
                 $urandom_range(32, 47), st);
      finish_check("rand", d, c, st, 3);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
